// File: rtl/comm_pkg.sv
// Shared types and constants for the command master and its UART serializer.
package comm_pkg;

   // Clocks per UART bit: 50 MHz system clock at 19200 baud.
   localparam int unsigned BAUD_DIV_DEF = 2604;

   // Start bit + 8 data bits + stop bit.
   localparam int unsigned FRAME_BITS = 10;

   // Command sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_HI = 2'd1,
      SEND_LO = 2'd2
   } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART byte serializer: start bit, eight data bits LSB first, stop bit.
// The shift register idles at all-ones so TX rests high without extra muxing.
module uart_tx
   import comm_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   localparam int unsigned     CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       shift_q, shift_d;
   logic             done_q, done_d;
   logic             bit_end;

   // Frame sequencing: load on strobe, advance one bit per baud period.
   always_comb begin
      busy_d     = busy_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      done_d     = 1'b0;
      bit_end    = busy_q && (baud_cnt_q == BAUD_LAST);

      if (!busy_q) begin
         if (trmt) begin
            busy_d     = 1'b1;
            shift_d    = {1'b1, tx_data, 1'b0};
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      end else if (bit_end) begin
         baud_cnt_d = '0;
         if (bit_cnt_q == BIT_LAST) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b1, shift_q[9:1]};
         end
      end else begin
         baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end
   end

   // Serializer state; reset drives the line high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '1;
         done_q     <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
      end
   end

   assign TX      = shift_q[0];
   assign tx_done = done_q;

endmodule

// File: rtl/comm_master.sv
// Sends a 16-bit command as two UART bytes, high byte first, and flags completion.
module comm_master
   import comm_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd_cmd,
   input  logic [15:0] cmd,
   output logic        TX,
   output logic        cmd_cmplt
);

   state_t      state_q, state_d;
   logic [15:0] held_q, held_d;
   logic        cmplt_q, cmplt_d;
   logic        trmt_q, trmt_d;
   logic        tx_done;
   logic [7:0]  tx_byte;

   // Next-state and strobe generation; inputs are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      cmplt_d = cmplt_q;
      trmt_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (snd_cmd) begin
               held_d  = cmd;
               cmplt_d = 1'b0;
               trmt_d  = 1'b1;
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            if (tx_done) begin
               trmt_d  = 1'b1;
               state_d = SEND_LO;
            end
         end
         SEND_LO: begin
            if (tx_done) begin
               cmplt_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, holding register and strobe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         held_q  <= '0;
         cmplt_q <= 1'b0;
         trmt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         cmplt_q <= cmplt_d;
         trmt_q  <= trmt_d;
      end
   end

   // The strobe and the state change land on the same edge, so the state
   // already names the byte the serializer is about to latch.
   assign tx_byte   = (state_q == SEND_LO) ? held_q[7:0] : held_q[15:8];
   assign cmd_cmplt = cmplt_q;

   uart_tx #(
      .BAUD_DIV(BAUD_DIV)
   ) u_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .trmt   (trmt_q),
      .tx_data(tx_byte),
      .TX     (TX),
      .tx_done(tx_done)
   );

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master with a 16-clock bit period.
module tb_comm_master;

   localparam int unsigned BD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        snd_cmd = 1'b0;
   logic [15:0] cmd = '0;
   logic        TX;
   logic        cmd_cmplt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // Posedge counter used to time events against the send edge.
   always @(posedge clk) cyc <= cyc + 1;

   comm_master #(
      .BAUD_DIV(BD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .snd_cmd  (snd_cmd),
      .cmd      (cmd),
      .TX       (TX),
      .cmd_cmplt(cmd_cmplt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a start bit, then samples 160 negedges of one frame.
   task automatic get_frame(output logic [7:0] data, output bit ok, output bit found,
                            output int start_cyc);
      logic [159:0] s;
      s = '0;
      data = '0;
      ok = 1'b0;
      found = 1'b0;
      start_cyc = -1;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (TX === 1'b0) found = 1'b1;
      end
      if (found) begin
         start_cyc = cyc;
         s[0] = TX;
         for (int i = 1; i < 160; i++) begin
            @(negedge clk);
            s[i] = TX;
         end
         ok = 1'b1;
         for (int i = 0; i < 16; i++) begin
            if (s[i] !== 1'b0) ok = 1'b0;
            if (s[144+i] !== 1'b1) ok = 1'b0;
         end
         for (int b = 0; b < 8; b++) begin
            data[b] = s[16+16*b];
            for (int j = 0; j < 16; j++)
               if (s[16+16*b+j] !== data[b]) ok = 1'b0;
         end
      end
   endtask

   // Bounded wait for cmd_cmplt to rise; returns the cycle it was seen.
   task automatic wait_cmplt(output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < 20 && at_cyc < 0; i++) begin
         @(negedge clk);
         if (cmd_cmplt === 1'b1) at_cyc = cyc;
      end
   endtask

   // One full command: pulse snd_cmd, decode both frames, time completion.
   task automatic send_word(input logic [15:0] word, input bit glitch);
      logic [7:0] d;
      bit ok, found;
      int st, t0, rise;
      @(negedge clk);
      cmd = word;
      snd_cmd = 1'b1;
      @(negedge clk);
      t0 = cyc;
      snd_cmd = 1'b0;
      check("cmplt_clear_at_start", cmd_cmplt, 0);
      if (glitch) cmd = 16'hFFFF;
      get_frame(d, ok, found, st);
      check("hi_found", found, 1);
      check("hi_data", d, word[15:8]);
      check("hi_framing", ok, 1);
      check("hi_start_offset", st - t0, 1);
      get_frame(d, ok, found, st);
      check("lo_found", found, 1);
      check("lo_data", d, word[7:0]);
      check("lo_framing", ok, 1);
      check("lo_start_offset", st - t0, 163);
      check("cmplt_low_before_done", cmd_cmplt, 0);
      wait_cmplt(rise);
      check("cmplt_rise_offset", rise - t0, 324);
   endtask

   initial begin
      logic [7:0] d;
      bit ok, found, quiet;
      int st, t0, rise;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", TX, 1);
      check("rst_cmplt", cmd_cmplt, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_tx", TX, 1);
      check("idle_cmplt", cmd_cmplt, 0);

      // Alternating pattern; cmd_cmplt must then hold
      send_word(16'h5555, 1'b0);
      repeat (20) @(negedge clk);
      check("cmplt_held", cmd_cmplt, 1);
      check("tx_idle_after", TX, 1);

      // Mixed pattern, then the same with cmd overwritten mid-transfer
      send_word(16'hA5C3, 1'b0);
      send_word(16'hA5C3, 1'b1);

      // Reset during the second byte
      @(negedge clk);
      cmd = 16'h3C96;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      get_frame(d, ok, found, st);
      check("abort_hi_data", d, 8'h3C);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (TX === 1'b0) found = 1'b1;
      end
      check("abort_lo_started", found, 1);
      repeat (20) @(negedge clk);
      check("abort_tx_mid_bit", TX, 0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_tx_async", TX, 1);
      check("abort_cmplt_async", cmd_cmplt, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (TX !== 1'b1 || cmd_cmplt !== 1'b0) quiet = 1'b0;
      end
      check("abort_line_quiet", quiet, 1);
      send_word(16'h3C96, 1'b0);

      // snd_cmd held high from reset release: back-to-back pairs
      @(negedge clk);
      rst_n = 1'b0;
      cmd = 16'h1234;
      snd_cmd = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      t0 = cyc;
      get_frame(d, ok, found, st);
      check("b2b_hi1_data", d, 8'h12);
      check("b2b_hi1_offset", st - t0, 1);
      get_frame(d, ok, found, st);
      check("b2b_lo1_data", d, 8'h34);
      check("b2b_lo1_offset", st - t0, 163);
      wait_cmplt(rise);
      check("b2b_cmplt1_offset", rise - t0, 324);
      cmd = 16'h5AA5;
      @(negedge clk);
      check("b2b_cmplt_reclear", cmd_cmplt, 0);
      get_frame(d, ok, found, st);
      check("b2b_hi2_data", d, 8'h5A);
      check("b2b_hi2_offset", st - t0, 326);
      snd_cmd = 1'b0;
      get_frame(d, ok, found, st);
      check("b2b_lo2_data", d, 8'hA5);
      check("b2b_lo2_framing", ok, 1);
      check("b2b_lo2_offset", st - t0, 488);
      wait_cmplt(rise);
      check("b2b_cmplt2_offset", rise - t0, 649);
      repeat (30) @(negedge clk);
      check("b2b_cmplt_held", cmd_cmplt, 1);
      check("b2b_tx_idle", TX, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/comm_master.md
COMM_MASTER -- requirements
Module: comm_master

Interface
REQ-001 BAUD_DIV, default 2604, clocks per UART bit period (50 MHz clk / 19200 baud).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 snd_cmd  input  1  level request to send cmd; sampled only in IDLE.
REQ-005 cmd  input  16  travel-plan command word, captured when a send starts.
REQ-006 TX  output  1  serial UART line, 8N1, idle high.
REQ-007 cmd_cmplt  output  1  high once both bytes of the current command have been sent.

Function
REQ-008 The block SHALL have three states: IDLE, SEND_HI and SEND_LO.
REQ-009 In IDLE with snd_cmd=1, the block SHALL latch cmd into a 16-bit holding register, clear cmd_cmplt, issue a one-cycle transmit strobe for cmd[15:8] and enter SEND_HI, all on the same edge.
REQ-010 In SEND_HI, on tx_done from the transmitter, the block SHALL issue a transmit strobe for held[7:0] and enter SEND_LO.
REQ-011 In SEND_LO, on tx_done, the block SHALL set cmd_cmplt and return to IDLE.
REQ-012 cmd_cmplt SHALL stay high until the next send starts (REQ-009) or reset.
REQ-013 Changes on cmd or snd_cmd outside IDLE SHALL be ignored; the held word SHALL be the one transmitted.
REQ-014 snd_cmd held high continuously SHALL cause back-to-back transfers: re-entry to IDLE with snd_cmd=1 starts a new transfer on the next edge.
REQ-015 Each byte frame SHALL be one start bit (0), eight data bits LSB first, then one stop bit (1), each lasting exactly BAUD_DIV clocks (10*BAUD_DIV clocks per byte).
REQ-016 The start bit SHALL appear on TX on the clock after the transmit strobe.
REQ-017 tx_done SHALL pulse for one clock at the end of the stop bit.
REQ-018 The second frame SHALL follow the first with at most 2 clocks of idle-high TX between frames.
REQ-019 The baud counter SHALL be wide enough for BAUD_DIV-1 and SHALL reset to 0 at each bit boundary.
REQ-020 The bit counter SHALL count 0..9 and SHALL not wrap inside a frame.

Reset
REQ-021 While rst_n=0, the block SHALL hold: state IDLE, TX=1, cmd_cmplt=0, holding register 0, baud/bit counters 0, no strobe pending.
REQ-022 Reset asserted mid-transfer SHALL abort the frame immediately (TX=1 asynchronously) and SHALL not emit tx_done.
REQ-023 After reset, the first snd_cmd=1 seen in IDLE SHALL start a transfer.

Structure
REQ-024 The byte serializer SHALL be a sub-module uart_tx (ports clk, rst_n, trmt, tx_data[7:0], TX, tx_done) parameterized by BAUD_DIV.
REQ-025 A shared package comm_pkg SHALL hold the state enum typedef and the default BAUD_DIV constant.
REQ-026 comm_master SHALL contain only the sequencing FSM and the holding register.

Verification
REQ-027 cmd=16'h5555 with snd_cmd pulsed one cycle -> TX sends byte 0x55, then byte 0x55; cmd_cmplt rises about 20*BAUD_DIV clocks after the strobe.
REQ-028 cmd=16'hA5C3 -> first frame data bits decode to 0xA5, second to 0xC3; start and stop bits are correct on each frame.
REQ-029 cmd changed to 16'hFFFF during SEND_HI -> decoded bytes are still 0xA5, 0xC3.
REQ-030 snd_cmd held at 1 from reset release -> repeated HI/LO pairs; cmd_cmplt goes high after each pair and clears at the next start.
REQ-031 rst_n=0 in the middle of the second byte -> TX=1 and cmd_cmplt=0 immediately; after release, a new snd_cmd sends the full word again.
REQ-032 BAUD_DIV=16 override -> every bit lasts exactly 16 clocks; one byte takes 160 clocks.
